// File: rtl/bta_operand_sequencer_pkg.sv
// Shared types and helpers for the tree-adder operand sequencer.
// Holds the state encoding, sum width derivation and the slot-to-bus mapping.
package bta_operand_sequencer_pkg;

  localparam int unsigned DEF_N         = 16;
  localparam int unsigned DEF_M         = 16;
  localparam int unsigned DEF_ADDER_LAT = 64;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BUS_A = 2'd0,
    BUS_B = 2'd1,
    BUS_C = 2'd2,
    BUS_D = 2'd3
  } bus_t;

  function automatic int unsigned sum_width(input int unsigned m, input int unsigned n);
    return m + $clog2(n);
  endfunction

  // First half of the frame feeds A/B, second half C/D; even slots A/C, odd B/D.
  function automatic bus_t slot_bus(input int unsigned k, input int unsigned n);
    logic hi;
    logic odd;
    hi  = (k >= n / 2);
    odd = k[0];
    return bus_t'({hi, odd});
  endfunction

  function automatic int unsigned slot_lane(input int unsigned k, input int unsigned n);
    return (k % (n / 2)) >> 1;
  endfunction

endpackage

// File: rtl/bta_lat_counter.sv
// Loadable down-counter with zero flag, used to time the adder latency.
// Stops at zero; a load always wins over counting.
module bta_lat_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bta_operand_sequencer.sv
// Operand feeder and result capture for the 16-operand binary-tree adder.
// Packs a stream of operands onto four buses, waits the adder latency, then presents the sum.
module bta_operand_sequencer
  import bta_operand_sequencer_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned M         = DEF_M,
  parameter int unsigned ADDER_LAT = DEF_ADDER_LAT,
  parameter int unsigned SW        = sum_width(DEF_M, DEF_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_sum,
  output logic              out_carry,
  output logic              out_err,
  output logic [M*N/4-1:0]  op_a,
  output logic [M*N/4-1:0]  op_b,
  output logic [M*N/4-1:0]  op_c,
  output logic [M*N/4-1:0]  op_d,
  output logic              op_c0,
  input  logic [SW-1:0]     add_sum,
  input  logic              add_carry
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned LW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          hs;
  logic          at_final;
  logic          frame_end;
  logic          frame_err;
  logic          wzero;
  logic          wait_en;
  int unsigned   idx;
  int unsigned   lane;
  bus_t          sel;

  assign op_c0     = 1'b0;
  assign hs        = in_valid && in_ready;
  assign at_final  = (count == CW'(N - 1));
  assign frame_end = hs && (in_last || at_final);
  // Error when in_last and the final slot disagree: early last or a missing last.
  assign frame_err = hs && (in_last != at_final);
  assign wait_en   = (state == WAIT);

  bta_lat_counter #(
    .W(LW)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_end),
    .load_val (LW'(ADDER_LAT - 1)),
    .en       (wait_en),
    .zero     (wzero)
  );

  always_comb begin
    idx  = 32'(count);
    sel  = slot_bus(idx, N);
    lane = slot_lane(idx, N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_end) state_next = WAIT;
      WAIT:    if (wzero) state_next = RESULT;
      RESULT:  if (out_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == RESULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      op_d      <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (hs) begin
        count <= count + CW'(1);
        case (sel)
          BUS_A: op_a[M*lane +: M] <= in_data;
          BUS_B: op_b[M*lane +: M] <= in_data;
          BUS_C: op_c[M*lane +: M] <= in_data;
          BUS_D: op_d[M*lane +: M] <= in_data;
        endcase
        if (frame_err) out_err <= 1'b1;
      end
      if (state == WAIT && wzero) begin
        out_sum   <= add_sum;
        out_carry <= add_carry;
      end
      if (state == RESULT && out_ready) begin
        count   <= '0;
        op_a    <= '0;
        op_b    <= '0;
        op_c    <= '0;
        op_d    <= '0;
        out_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bta_operand_sequencer.sv
// Bench for the operand sequencer with a pipelined tree-adder model and a result scoreboard.
module tb_bta_operand_sequencer;

  localparam int N   = 16;
  localparam int M   = 16;
  localparam int LAT = 64;
  localparam int SW  = 20;
  localparam int BW  = M * N / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_carry;
  logic          out_err;
  logic [BW-1:0] op_a, op_b, op_c, op_d;
  logic          op_c0;
  logic [SW-1:0] add_sum;
  logic          add_carry;

  always #5 clk = ~clk;

  bta_operand_sequencer #(
    .N(N),
    .M(M),
    .ADDER_LAT(LAT),
    .SW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_err(out_err),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_c0(op_c0),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  // Tree adder model: sum of all lanes, LAT-1 register stages deep.
  logic [SW:0] pipe [LAT-1];
  always @(posedge clk) begin
    logic [SW:0] s;
    s = '0;
    for (int i = 0; i < N / 4; i++)
      s = s + op_a[M*i +: M] + op_b[M*i +: M] + op_c[M*i +: M] + op_d[M*i +: M];
    pipe[0] <= s;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign add_sum   = pipe[LAT-2][SW-1:0];
  assign add_carry = pipe[LAT-2][SW];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          err;
  } exp_t;

  exp_t sb[$];

  int   cyc        = 0;
  int   end_cyc    = -1;
  int   beat_n     = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      beat_n  = 0;
      end_cyc = -1;
    end else begin
      if (in_valid && in_ready) begin
        beat_n++;
        if (in_last || beat_n == N) begin
          end_cyc = cyc;
          beat_n  = 0;
        end
      end
      if (out_valid && !prev_valid && end_cyc >= 0) begin
        check("latency", 64'(cyc - end_cyc), 64'(LAT + 1));
        end_cyc = -1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_sum", 64'(out_sum), 64'(e.sum));
          check("out_err", 64'(out_err), 64'(e.err));
          check("out_carry", 64'(out_carry), 64'd0);
        end
      end
    end
    prev_valid = out_valid;
  end

  logic [M-1:0] fdata [N];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_beat(input logic [M-1:0] d, input logic l);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit use_last);
    exp_t        e;
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s = s + SW'(fdata[i]);
    e.sum = s;
    e.err = !use_last || (len != N);
    sb.push_back(e);
    for (int i = 0; i < len; i++) put_beat(fdata[i], use_last && (i == len - 1));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < LAT * 4) begin
      step(1);
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int len;
    bit use_last;
    logic [SW-1:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    check("rst_op_bus", 64'(op_a | op_b | op_c | op_d), 64'd0);
    check("op_c0", 64'(op_c0), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) fdata[i] = M'(i + 1);
    send_frame(16, 1'b1);
    wait_drain();

    for (int i = 0; i < N; i++) fdata[i] = 16'hFFFF;
    send_frame(16, 1'b1);
    wait_drain();

    fdata[0] = 16'd5; fdata[1] = 16'd6; fdata[2] = 16'd7;
    send_frame(3, 1'b1);
    @(negedge clk);
    check("pad_op_a", 64'(op_a), 64'h0000_0000_0007_0005);
    check("pad_op_b", 64'(op_b), 64'h0000_0000_0000_0006);
    check("pad_op_c", 64'(op_c), 64'd0);
    check("pad_op_d", 64'(op_d), 64'd0);
    @(posedge clk); #1;
    wait_drain();

    for (int i = 0; i < N; i++) fdata[i] = 16'h0001;
    send_frame(16, 1'b0);
    wait_drain();

    out_ready = 1'b0;
    for (int i = 0; i < N; i++) fdata[i] = M'($urandom);
    send_frame(16, 1'b1);
    seen = 0;
    while (!out_valid && seen < LAT * 2) begin
      step(1);
      seen++;
    end
    check("bp_valid_rise", 64'(out_valid), 64'd1);
    held     = sb[0].sum;
    in_valid = 1'b1; in_data = 16'h0002; in_last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_sum", 64'(out_sum), 64'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) fdata[i] = 16'h0002;
    send_frame(16, 1'b1);
    wait_drain();

    for (int i = 0; i < N; i++) fdata[i] = M'(i + 1);
    send_frame(16, 1'b1);
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_op_bus", 64'(op_a | op_b | op_c | op_d), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send_frame(16, 1'b1);
    wait_drain();

    repeat (4) begin
      len      = int'($urandom_range(1, 16));
      use_last = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) fdata[i] = M'($urandom);
      send_frame(len, use_last);
      wait_drain();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
